// File: rtl/spi_xfer_ctrl.sv
// SPI slave transfer controller: frames MOSI bits into fixed-size packets, shifts
// transmit words out on MISO, and holds the memory interface in reset outside ACTIVE.
module spi_xfer_ctrl #(
    parameter int PACKET_SIZE  = 40,
    parameter int PRIME_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_active,
    input  logic                   sclk_rise,
    input  logic                   sclk_fall,
    input  logic                   mosi,
    output logic                   miso,
    input  logic [PACKET_SIZE-1:0] toOutput,
    input  logic                   loadOutput,
    output logic [PACKET_SIZE-1:0] inputReg,
    output logic                   dataReady,
    output logic                   memif_reset,
    output logic [CNT_WIDTH-1:0]   packet_count,
    output logic                   frame_error
);

    localparam int BIT_W   = (PACKET_SIZE > 2) ? $clog2(PACKET_SIZE) : 1;
    localparam int PRIME_W = (PRIME_CYCLES > 2) ? $clog2(PRIME_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [BIT_W-1:0]     BIT_ZERO   = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]     BIT_ONE    = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0]     BIT_LAST   = BIT_W'(PACKET_SIZE - 1);
    localparam logic [PRIME_W-1:0]   PRIME_ZERO = {PRIME_W{1'b0}};
    localparam logic [PRIME_W-1:0]   PRIME_ONE  = PRIME_W'(1'b1);
    localparam logic [PRIME_W-1:0]   PRIME_LAST = PRIME_W'(PRIME_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1'b1);
    localparam logic [PACKET_SIZE-1:0] PKT_ZERO = {PACKET_SIZE{1'b0}};

    logic [1:0]             state_r,        state_s;
    logic [BIT_W-1:0]       bit_cnt_r,      bit_cnt_s;
    logic [PRIME_W-1:0]     prime_cnt_r,    prime_cnt_s;
    logic [PACKET_SIZE-1:0] shift_in_r,     shift_in_s;
    logic [PACKET_SIZE-1:0] shift_out_r,    shift_out_s;
    logic [PACKET_SIZE-1:0] input_reg_r,    input_reg_s;
    logic                   data_ready_r,   data_ready_s;
    logic                   memif_reset_r,  memif_reset_s;
    logic [CNT_WIDTH-1:0]   packet_count_r, packet_count_s;
    logic                   frame_error_r,  frame_error_s;
    logic                   shift_out_en_s;

    // Next-state and datapath decode; a rise always wins over a coincident fall.
    always_comb begin
        state_s        = state_r;
        bit_cnt_s      = bit_cnt_r;
        prime_cnt_s    = prime_cnt_r;
        shift_in_s     = shift_in_r;
        input_reg_s    = input_reg_r;
        data_ready_s   = 1'b0;
        packet_count_s = packet_count_r;
        frame_error_s  = frame_error_r;
        shift_out_en_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                bit_cnt_s = BIT_ZERO;
                if (cs_active) begin
                    state_s        = ST_PRIME;
                    prime_cnt_s    = PRIME_ZERO;
                    packet_count_s = CNT_ZERO;
                    frame_error_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (!cs_active) begin
                    state_s = ST_IDLE;
                end else begin
                    if (sclk_rise || sclk_fall) begin
                        frame_error_s = 1'b1;
                    end else begin
                        frame_error_s = frame_error_r;
                    end
                    if (prime_cnt_r == PRIME_LAST) begin
                        state_s = ST_ACTIVE;
                    end else begin
                        prime_cnt_s = prime_cnt_r + PRIME_ONE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!cs_active) begin
                    // A partial packet is dropped and flagged rather than delivered.
                    state_s   = ST_IDLE;
                    bit_cnt_s = BIT_ZERO;
                    if (bit_cnt_r != BIT_ZERO) begin
                        frame_error_s = 1'b1;
                    end else begin
                        frame_error_s = frame_error_r;
                    end
                end else if (sclk_rise) begin
                    shift_in_s = {shift_in_r[PACKET_SIZE-2:0], mosi};
                    if (sclk_fall) begin
                        frame_error_s = 1'b1;
                    end else begin
                        frame_error_s = frame_error_r;
                    end
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s      = BIT_ZERO;
                        input_reg_s    = {shift_in_r[PACKET_SIZE-2:0], mosi};
                        data_ready_s   = 1'b1;
                        packet_count_s = packet_count_r + CNT_ONE;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end
                end else if (sclk_fall) begin
                    // Hold at a packet boundary so a freshly loaded word keeps its MSB.
                    shift_out_en_s = (bit_cnt_r != BIT_ZERO);
                end else begin
                    shift_out_en_s = 1'b0;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = BIT_ZERO;
            end
        endcase

        if (loadOutput) begin
            shift_out_s = toOutput;
        end else if (shift_out_en_s) begin
            shift_out_s = {shift_out_r[PACKET_SIZE-2:0], 1'b0};
        end else begin
            shift_out_s = shift_out_r;
        end

        memif_reset_s = (state_s != ST_ACTIVE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            bit_cnt_r      <= BIT_ZERO;
            prime_cnt_r    <= PRIME_ZERO;
            shift_in_r     <= PKT_ZERO;
            shift_out_r    <= PKT_ZERO;
            input_reg_r    <= PKT_ZERO;
            data_ready_r   <= 1'b0;
            memif_reset_r  <= 1'b1;
            packet_count_r <= CNT_ZERO;
            frame_error_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            bit_cnt_r      <= bit_cnt_s;
            prime_cnt_r    <= prime_cnt_s;
            shift_in_r     <= shift_in_s;
            shift_out_r    <= shift_out_s;
            input_reg_r    <= input_reg_s;
            data_ready_r   <= data_ready_s;
            memif_reset_r  <= memif_reset_s;
            packet_count_r <= packet_count_s;
            frame_error_r  <= frame_error_s;
        end
    end

    assign miso         = shift_out_r[PACKET_SIZE-1];
    assign inputReg     = input_reg_r;
    assign dataReady    = data_ready_r;
    assign memif_reset  = memif_reset_r;
    assign packet_count = packet_count_r;
    assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomised bench for spi_xfer_ctrl: a transaction-level model predicts every output
// each cycle, and directed sessions pin the model with hand-computed values.
module tb_spi_xfer_ctrl;

    localparam int P  = 40;
    localparam int PC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cs_active = 1'b0;
    logic          sclk_rise = 1'b0;
    logic          sclk_fall = 1'b0;
    logic          mosi = 1'b0;
    logic          loadOutput = 1'b0;
    logic [P-1:0]  toOutput = '0;
    logic          miso;
    logic [P-1:0]  inputReg;
    logic          dataReady;
    logic          memif_reset;
    logic [CW-1:0] packet_count;
    logic          frame_error;

    spi_xfer_ctrl #(.PACKET_SIZE(P), .PRIME_CYCLES(PC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .cs_active(cs_active), .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall), .mosi(mosi), .miso(miso), .toOutput(toOutput),
        .loadOutput(loadOutput), .inputReg(inputReg), .dataReady(dataReady),
        .memif_reset(memif_reset), .packet_count(packet_count), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int dr_count = 0;
    logic [P-1:0] cap = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 priming, 2 active; tx tracked as word plus bits consumed.
    int           m_mode = 0;
    int           m_prime = 0;
    int           m_rxn = 0;
    int           m_txidx = 0;
    logic [P-1:0] m_acc = '0;
    logic [P-1:0] m_in = '0;
    logic [P-1:0] m_tx = '0;
    logic         m_dr = 1'b0;
    logic         m_ferr = 1'b0;
    logic         m_memrst = 1'b1;
    logic [CW-1:0] m_cnt = '0;

    task automatic model_step();
        if (!reset) begin
            m_mode = 0; m_prime = 0; m_rxn = 0; m_txidx = 0;
            m_acc = '0; m_in = '0; m_tx = '0; m_dr = 1'b0;
            m_ferr = 1'b0; m_memrst = 1'b1; m_cnt = '0;
            return;
        end
        if (loadOutput) begin
            m_tx = toOutput;
            m_txidx = 0;
        end else if (m_mode == 2 && cs_active && sclk_fall && !sclk_rise && m_rxn != 0) begin
            m_txidx++;
        end
        m_dr = 1'b0;
        case (m_mode)
            0: begin
                m_rxn = 0;
                if (cs_active) begin
                    m_mode = 1; m_prime = 0; m_cnt = '0; m_ferr = 1'b0;
                end
            end
            1: begin
                if (!cs_active) m_mode = 0;
                else begin
                    if (sclk_rise || sclk_fall) m_ferr = 1'b1;
                    m_prime++;
                    if (m_prime == PC) m_mode = 2;
                end
            end
            default: begin
                if (!cs_active) begin
                    m_mode = 0;
                    if (m_rxn != 0) m_ferr = 1'b1;
                    m_rxn = 0;
                end else if (sclk_rise) begin
                    m_acc = (m_acc << 1) | P'(mosi);
                    if (sclk_fall) m_ferr = 1'b1;
                    m_rxn++;
                    if (m_rxn == P) begin
                        m_rxn = 0; m_in = m_acc; m_dr = 1'b1; m_cnt = m_cnt + 1'b1;
                    end
                end
            end
        endcase
        m_memrst = (m_mode != 2);
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        logic exp_miso;
        @(negedge clk);
        exp_miso = (m_txidx < P) ? m_tx[P-1-m_txidx] : 1'b0;
        check("miso", 64'(miso), 64'(exp_miso));
        check("dataReady", 64'(dataReady), 64'(m_dr));
        check("inputReg", 64'(inputReg), 64'(m_in));
        check("memif_reset", 64'(memif_reset), 64'(m_memrst));
        check("packet_count", 64'(packet_count), 64'(m_cnt));
        check("frame_error", 64'(frame_error), 64'(m_ferr));
        if (dataReady) dr_count++;
    end

    task automatic step(input logic c, input logic r, input logic f, input logic m,
                        input logic ld, input logic [P-1:0] d);
        cs_active = c; sclk_rise = r; sclk_fall = f; mosi = m; loadOutput = ld; toOutput = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_bit(input logic b, input int half, input logic do_ld,
                            input logic [P-1:0] w, input logic both);
        cap = {cap[P-2:0], miso};
        step(1'b1, 1'b1, both, b, 1'b0, '0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, do_ld, w);
        idle(half - 3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(half - 1);
    endtask

    task automatic send_packet(input logic [P-1:0] data, input int half,
                               input logic do_ld, input logic [P-1:0] w);
        for (int i = P - 1; i >= 0; i--)
            send_bit(data[i], half, (i == 0) && do_ld, w, 1'b0);
    endtask

    // Raise chip select, optionally load a word and strobe SCLK early, then reach ACTIVE.
    task automatic open_session(input logic do_ld, input logic [P-1:0] w, input logic early);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, do_ld, w);
        step(1'b1, early, 1'b0, 1'b0, 1'b0, '0);
        idle(3);
    endtask

    task automatic close_session();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int dr_before;
        logic [P-1:0] rx [3];
        logic [P-1:0] tx [4];

        repeat (3) @(negedge clk);
        check("rst_memif_reset", 64'(memif_reset), 64'h1);
        check("rst_miso", 64'(miso), 64'h0);
        check("rst_inputReg", 64'(inputReg), 64'h0);
        check("rst_packet_count", 64'(packet_count), 64'h0);
        reset = 1'b1;
        close_session();

        // Single packet with a transmit word loaded during PRIME.
        open_session(1'b1, 40'h80_0000_0001, 1'b0);
        send_packet(40'h5A_5A5A_5A5A, 4, 1'b0, '0);
        check("single_inputReg", 64'(inputReg), 64'h5A_5A5A_5A5A);
        check("single_count", 64'(packet_count), 64'h1);
        check("single_ferr", 64'(frame_error), 64'h0);
        check("single_dr_pulses", 64'(dr_count), 64'h1);
        check("tx_word", 64'(cap), 64'h80_0000_0001);
        close_session();

        // Back-to-back packets with reloads two cycles after each dataReady.
        rx[0] = 40'h12_3456_789A; rx[1] = 40'hFE_DCBA_9876; rx[2] = 40'h00_FF00_FF01;
        tx[0] = 40'hC3_0000_00A5; tx[1] = 40'h81_2481_2481; tx[2] = 40'hF0_F0F0_F0F0;
        tx[3] = 40'h0;
        open_session(1'b1, tx[0], 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_packet(rx[k], 5, 1'b1, tx[k+1]);
            check("b2b_tx", 64'(cap), 64'(tx[k]));
            check("b2b_rx", 64'(inputReg), 64'(rx[k]));
        end
        check("b2b_count", 64'(packet_count), 64'h3);
        close_session();
        check("b2b_ferr", 64'(frame_error), 64'h0);

        // Abort after 17 bits, then a new chip select clears the error.
        dr_before = dr_count;
        open_session(1'b0, '0, 1'b0);
        for (int i = 0; i < 17; i++) send_bit(1'b1, 4, 1'b0, '0, 1'b0);
        close_session();
        check("abort_ferr", 64'(frame_error), 64'h1);
        check("abort_memif", 64'(memif_reset), 64'h1);
        check("abort_no_dr", 64'(dr_count), 64'(dr_before));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("abort_clear", 64'(frame_error), 64'h0);
        close_session();

        // SCLK rise in PRIME flags an error but the first packet still lands.
        open_session(1'b0, '0, 1'b1);
        check("early_ferr", 64'(frame_error), 64'h1);
        send_packet(40'hA5_0F1E_2D3C, 4, 1'b0, '0);
        check("early_rx", 64'(inputReg), 64'hA5_0F1E_2D3C);
        check("early_count", 64'(packet_count), 64'h1);
        close_session();

        // Coincident rise and fall: rise is taken, error flagged.
        open_session(1'b0, '0, 1'b0);
        send_bit(1'b1, 4, 1'b0, '0, 1'b1);
        check("both_ferr", 64'(frame_error), 64'h1);
        close_session();

        // Asynchronous reset partway through a packet.
        dr_before = dr_count;
        open_session(1'b1, 40'hFF_FFFF_FFFF, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 4, 1'b0, '0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("areset_memif", 64'(memif_reset), 64'h1);
        check("areset_miso", 64'(miso), 64'h0);
        check("areset_dr", 64'(dataReady), 64'h0);
        check("areset_inputReg", 64'(inputReg), 64'h0);
        check("areset_count", 64'(packet_count), 64'h0);
        check("areset_ferr", 64'(frame_error), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        close_session();
        check("areset_no_dr", 64'(dr_count), 64'(dr_before));

        // Randomised sessions checked by the per-cycle model comparison.
        for (int s = 0; s < 14; s++) begin
            int half, npk, abort_at, exp_dr;
            logic [P-1:0] w;
            half = int'($urandom_range(4, 7));
            npk = int'($urandom_range(1, 3));
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, P - 1)) : -1;
            exp_dr = dr_count + npk;
            open_session($urandom_range(0, 1) == 1, P'({$urandom(), $urandom()}),
                         $urandom_range(0, 3) == 0);
            for (int k = 0; k < npk; k++) begin
                w = P'({$urandom(), $urandom()});
                for (int i = P - 1; i >= 0; i--)
                    send_bit(w[i], half, i == 0, P'({$urandom(), $urandom()}),
                             $urandom_range(0, 60) == 0);
                check("rand_rx", 64'(inputReg), 64'(w));
            end
            if (abort_at > 0) begin
                for (int i = 0; i < abort_at; i++)
                    send_bit($urandom_range(0, 1) == 1, half, 1'b0, '0, 1'b0);
            end
            close_session();
            check("rand_dr_count", 64'(dr_count), 64'(exp_dr));
            if (abort_at > 0) check("rand_abort_ferr", 64'(frame_error), 64'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
